// File: rtl/sensor_pkg.sv
// Shared types and packet layout for the sensor packetizer.
// Optional change-threshold filtering is enabled with SENSOR_PKT_DELTA_EN.
package sensor_pkg;

    localparam int DATA_W      = 8;
    localparam int PKT_W       = 24;
    localparam int PKT_ID_LSB  = 16;
    localparam int PKT_SEQ_LSB = 8;
    localparam int PKT_AVG_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_CAPTURE,
        ST_SEND
    } state_t;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [7:0]        id,
        input logic [7:0]        seq,
        input logic [DATA_W-1:0] avg
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[PKT_ID_LSB  +: 8]      = id;
        p[PKT_SEQ_LSB +: 8]      = seq;
        p[PKT_AVG_LSB +: DATA_W] = avg;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] abs_diff(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/sample_accumulator.sv
// Sums a power-of-two block of samples; avg reflects the sum including
// the sample being added this cycle, so it is ready on the final add.
module sample_accumulator
    import sensor_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] avg
);

    localparam int AW = DATA_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] DONE_AT = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [CW-1:0] count;

    assign sum  = acc + AW'(data);
    assign avg  = DATA_W'(sum >> AVG_LOG2);
    assign done = (count == DONE_AT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            count <= '0;
        end else if (add) begin
            acc   <= sum;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_packetizer.sv
// Strobes the sensor, averages sample blocks and frames them as packets.
// Define SENSOR_PKT_DELTA_EN to send only averages that moved by >= DELTA.
module sensor_packetizer
    import sensor_pkg::*;
#(
    parameter int          SAMPLE_PERIOD = 16,
    parameter int          AVG_LOG2      = 2,
    parameter logic [7:0]  NODE_ID       = 8'h01,
    parameter int          DELTA         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sensor_en,
    input  logic [DATA_W-1:0] sensor_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [PW-1:0] WAIT_LAST = PW'(SAMPLE_PERIOD - 1);

    if (SAMPLE_PERIOD < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4 ||
        DELTA < 0 || DELTA > 255) begin : g_bad_cfg
        $error("sensor_packetizer: parameter out of range");
    end

    state_t            state;
    logic [PW-1:0]     cnt;
    logic [7:0]        seq;
    logic              clr;
    logic              add;
    logic              done;
    logic              keep;
    logic [DATA_W-1:0] avg;

`ifdef SENSOR_PKT_DELTA_EN
    logic [DATA_W-1:0] last_avg;
    logic              sent;

    assign keep = !sent || (int'(abs_diff(avg, last_avg)) >= DELTA);
`else
    assign keep = 1'b1;
`endif

    assign add = (state == ST_CAPTURE);
    assign clr = (state == ST_IDLE)
              || (state == ST_SEND && pkt_ready)
              || (state == ST_CAPTURE && done && !keep);

    sample_accumulator #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .add  (add),
        .data (sensor_data),
        .done (done),
        .avg  (avg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            seq       <= '0;
            sensor_en <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            busy      <= 1'b0;
`ifdef SENSOR_PKT_DELTA_EN
            last_avg  <= '0;
            sent      <= 1'b0;
`endif
        end else begin
            sensor_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= ST_WAIT;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!start) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == WAIT_LAST) begin
                            state     <= ST_STROBE;
                            sensor_en <= 1'b1;
                        end
                    end
                end
                ST_STROBE: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    cnt <= '0;
                    if (!done) begin
                        state <= ST_WAIT;
                    end else if (keep) begin
                        state     <= ST_SEND;
                        pkt_valid <= 1'b1;
                        pkt_data  <= make_pkt(NODE_ID, seq, avg);
                    end else begin
                        state <= start ? ST_WAIT : ST_IDLE;
                        busy  <= start;
                    end
                end
                ST_SEND: begin
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        seq       <= seq + 1'b1;
                        state     <= start ? ST_WAIT : ST_IDLE;
                        busy      <= start;
`ifdef SENSOR_PKT_DELTA_EN
                        last_avg  <= pkt_data[PKT_AVG_LSB +: DATA_W];
                        sent      <= 1'b1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_packetizer.sv
// Randomised bench for sensor_packetizer with a queue-based block-average
// model, per-cycle protocol checks and a few literal packet expectations.
module tb_sensor_packetizer;

    localparam int         SP  = 4;
    localparam int         L   = 2;
    localparam int         N   = 1 << L;
    localparam logic [7:0] NID = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sensor_en;
    logic [7:0]  sensor_data = 8'h00;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] pkt_data;
    logic        busy;

    always #5 clk = ~clk;

    sensor_packetizer #(
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (L),
        .NODE_ID       (NID),
        .DELTA         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sensor_en   (sensor_en),
        .sensor_data (sensor_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .busy        (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Behavioural model: sensor values in order, grouped into blocks of N
    logic [7:0]  force_q[$];
    logic [7:0]  smp_q[$];
    logic [7:0]  exp_q[$];
    logic [23:0] acc_log[$];
    int          seq_m   = 0;
    bit          first_m = 1'b1;
    int          last_m  = 0;

    function automatic void close_block();
        int sum;
        int a;
        sum = 0;
        foreach (smp_q[i]) sum += int'(smp_q[i]);
        a = sum / N;
        smp_q.delete();
`ifdef SENSOR_PKT_DELTA_EN
        if (first_m || (a - last_m >= 4) || (last_m - a >= 4)) begin
            exp_q.push_back(8'(a));
            last_m  = a;
            first_m = 1'b0;
        end
`else
        exp_q.push_back(8'(a));
`endif
    endfunction

    always @(posedge clk) begin
        logic [7:0] v;
        if (sensor_en && !rst) begin
            v = (force_q.size() > 0) ? force_q.pop_front() : 8'($urandom);
            sensor_data <= v;
            smp_q.push_back(v);
            if (smp_q.size() == N) close_block();
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
    end

    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [23:0] prev_data  = '0;
    int          last_en    = 0;
    bit          armed      = 1'b0;
    bit          first_pend = 1'b0;
    int          start_cyc  = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            armed      = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("hold_valid", 32'(pkt_valid), 32'd1);
                check("hold_data", 32'(pkt_data), 32'(prev_data));
            end
            if (prev_hs) check("valid_drop", 32'(pkt_valid), 32'd0);
            if (pkt_valid && !prev_valid)
                check("valid_latency", 32'(cyc - last_en), 32'd2);
            if (sensor_en) begin
                check("no_en_in_send", 32'(pkt_valid), 32'd0);
                if (armed)
                    check("en_spacing", 32'(cyc - last_en), 32'(SP + 2));
                if (first_pend)
                    check("first_en", 32'(cyc - start_cyc), 32'(SP + 1));
                first_pend = 1'b0;
                last_en    = cyc;
                armed      = 1'b1;
            end
            if (pkt_valid || !start) armed = 1'b0;
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_pkt");
                end else begin
                    check("pkt_data", 32'(pkt_data),
                          32'({NID, 8'(seq_m), exp_q.pop_front()}));
                end
                seq_m++;
                acc_log.push_back(pkt_data);
            end
            prev_valid = pkt_valid;
            prev_hs    = pkt_valid && pkt_ready;
            prev_data  = pkt_data;
        end
    end

    function automatic logic [23:0] last_pkt();
        return (acc_log.size() > 0) ? acc_log[acc_log.size()-1] : 24'hxxxxxx;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        smp_q.delete();
        exp_q.delete();
        force_q.delete();
        seq_m   = 0;
        first_m = 1'b1;
        last_m  = 0;
        rst     = 1'b0;
    endtask

    task automatic raise_start();
        start      = 1'b1;
        start_cyc  = cyc;
        first_pend = 1'b1;
    endtask

    task automatic wait_pkts(input int n, input int budget);
        int target;
        target = acc_log.size() + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (acc_log.size() >= target) return;
        end
        fail("wait_pkts_timeout");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (pkt_valid) return;
        end
        fail("wait_valid_timeout");
    endtask

    task automatic wait_en();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sensor_en) return;
        end
        fail("wait_en_timeout");
    endtask

    initial begin
        int b;
        int en_cnt;
        rst       = 1'b1;
        start     = 1'b0;
        pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sensor_en", 32'(sensor_en), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_pkt_data", 32'(pkt_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef SENSOR_PKT_DELTA_EN
        // 0+15+80+95 = 190, >>2 = 47 = 0x2F
        force_q = '{8'h00, 8'h0F, 8'h50, 8'h5F};
        raise_start();
        wait_pkts(1, 200);
        check("avg_pkt", 32'(last_pkt()), 32'h00A5002F);
        check("busy_run", 32'(busy), 32'd1);

        do_reset();
        repeat (3 * N) force_q.push_back(8'hFF);
        b = acc_log.size();
        raise_start();
        wait_pkts(3, 300);
        for (int k = 0; k < 3; k++) begin
            if (b + k < acc_log.size())
                check("fullscale_pkt", 32'(acc_log[b+k]),
                      32'({8'hA5, 8'(k), 8'hFF}));
            else
                fail("fullscale_missing");
        end

        pkt_ready = 1'b0;
        wait_valid();
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            en_cnt += int'(sensor_en);
        end
        check("bp_no_en", 32'(en_cnt), 32'd0);
        check("bp_valid", 32'(pkt_valid), 32'd1);
        pkt_ready = 1'b1;
        b = acc_log.size();
        @(posedge clk);
        #1;
        check("bp_accept", 32'(acc_log.size() - b), 32'd1);
        check("bp_seq", 32'(last_pkt()), 32'(acc_log[acc_log.size()-1]));

        wait_en();
        wait_en();
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        smp_q.delete();
        b = acc_log.size();
        repeat (8) @(posedge clk);
        #1;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_no_pkt", 32'(acc_log.size() - b), 32'd0);
        // 16+32+48+64 = 160, >>2 = 40 = 0x28; fifth packet since reset
        force_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        raise_start();
        wait_pkts(1, 200);
        check("restart_pkt", 32'(last_pkt()), 32'h00A50428);

        pkt_ready = 1'b0;
        wait_valid();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_send_valid", 32'(pkt_valid), 32'd0);
        check("rst_send_busy", 32'(busy), 32'd0);
        do_reset();
        pkt_ready = 1'b1;
        raise_start();
        wait_pkts(1, 200);
        check("rst_seq", 32'(last_pkt()) >> 8 & 32'hFF, 32'd0);

        do_reset();
        rand_ready = 1'b1;
        b = acc_log.size();
        raise_start();
        wait_pkts(258, 15000);
        rand_ready = 1'b0;
        #2;
        pkt_ready = 1'b1;
        if (acc_log.size() >= b + 258) begin
            check("wrap_ff", 32'(acc_log[b+255][15:8]), 32'hFF);
            check("wrap_00", 32'(acc_log[b+256][15:8]), 32'h00);
            check("wrap_01", 32'(acc_log[b+257][15:8]), 32'h01);
        end else begin
            fail("wrap_missing");
        end
`else
        do_reset();
        repeat (N) force_q.push_back(8'h40);
        repeat (N) force_q.push_back(8'h42);
        repeat (N) force_q.push_back(8'h45);
        b = acc_log.size();
        raise_start();
        repeat (3 * N * (SP + 2) + 20) @(posedge clk);
        #1;
        check("delta_count", 32'(acc_log.size() - b), 32'd2);
        if (acc_log.size() >= b + 2) begin
            check("delta_first", 32'(acc_log[b]), 32'h00A50040);
            check("delta_second", 32'(acc_log[b+1]), 32'h00A50145);
        end
        rand_ready = 1'b1;
        wait_pkts(20, 4000);
        rand_ready = 1'b0;
        #2;
        pkt_ready = 1'b1;
`endif

        start = 1'b0;
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
